// File: rtl/irq_conditioner_if.sv
// rtl/irq_conditioner_if.sv - raw interrupt, configuration and pulse bundle for irq_conditioner
interface irq_conditioner_if #(
    parameter int HOLDOFF_W = 4
);
    logic [6:0]           raw_irq;
    logic                 mask_wr;
    logic [6:0]           mask_data;
    logic                 mode_wr;
    logic [6:0]           mode_data;
    logic [HOLDOFF_W-1:0] holdoff;
    logic                 ovr_clr;
    logic [6:0]           irq_out;
    logic [6:0]           pending;
    logic [6:0]           overrun;

    modport master (
        output raw_irq, mask_wr, mask_data, mode_wr, mode_data, holdoff, ovr_clr,
        input  irq_out, pending, overrun
    );

    modport slave (
        input  raw_irq, mask_wr, mask_data, mode_wr, mode_data, holdoff, ovr_clr,
        output irq_out, pending, overrun
    );
endinterface

// File: rtl/irq_conditioner.sv
// rtl/irq_conditioner.sv - synchronise, mask and space 7 interrupt lines into single-cycle pulses
module irq_conditioner #(
    parameter int HOLDOFF_W   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    irq_conditioner_if.slave   bus
);
    localparam int N = 7;
    localparam logic [HOLDOFF_W-1:0] CNT_ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};

    logic [N-1:0]         sync_q [SYNC_STAGES];
    logic [N-1:0]         prev_q;
    logic [N-1:0]         mask_q;
    logic [N-1:0]         mode_q;
    logic [N-1:0]         pend_q;
    logic [N-1:0]         ovr_q;
    logic [N-1:0]         irq_q;
    logic [HOLDOFF_W-1:0] cnt_q [N];

    logic [N-1:0]         s;
    logic [N-1:0]         ev;
    logic [N-1:0]         cnt_zero;
    logic [N-1:0]         em;
    logic [N-1:0]         ovr_set;
    logic [HOLDOFF_W-1:0] reload;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_zero = '0;
        for (int i = 0; i < N; i++) begin
            cnt_zero[i] = (cnt_q[i] == '0);
        end
    end

    // Level lines see an event every cycle they are high; edge lines only on 0->1.
    assign ev      = mask_q & ((mode_q & s) | (~mode_q & s & ~prev_q));
    assign em      = mask_q & cnt_zero & (pend_q | ev);
    assign ovr_set = ~mode_q & ev & pend_q & ~em;
    assign reload  = (bus.holdoff == '0) ? '0 : bus.holdoff - CNT_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
            irq_q  <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.raw_irq;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= s;
            if (bus.mask_wr) begin
                mask_q <= bus.mask_data;
            end
            if (bus.mode_wr) begin
                mode_q <= bus.mode_data;
            end
            irq_q  <= em;
            // A masked line has ev=0 and em=0, so its pending bit simply holds.
            pend_q <= (pend_q | ev) & ~em;
            ovr_q  <= ovr_set | (bus.ovr_clr ? '0 : ovr_q);
            for (int i = 0; i < N; i++) begin
                if (em[i]) begin
                    cnt_q[i] <= reload;
                end else if (!cnt_zero[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_ONE;
                end
            end
        end
    end

    assign bus.irq_out = irq_q;
    assign bus.pending = pend_q;
    assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_irq_conditioner.sv
// tb/tb_irq_conditioner.sv - scoreboard bench for irq_conditioner
module tb_irq_conditioner;
    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;

    typedef struct {
        int         cyc;
        logic [6:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    irq_conditioner_if #(.HOLDOFF_W(4)) bus ();

    irq_conditioner #(
        .HOLDOFF_W   (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulses are popped from the scoreboard as they appear; missing ones are caught when overdue.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            $display("FAIL missed_pulse: expected irq_out=%h at cycle %0d, irq_out stayed 00", mon_e.val, mon_e.cyc);
        end
        if (bus.irq_out !== 7'h00) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: irq_out=%h at cycle %0d, expected 00", bus.irq_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cyc !== cyc || mon_e.val !== bus.irq_out) begin
                    $display("FAIL pulse: got irq_out=%h at cycle %0d, expected %h at cycle %0d",
                             bus.irq_out, cyc, mon_e.val, mon_e.cyc);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic push_exp(input int c, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic cfg_mask(input logic [6:0] m);
        bus.mask_wr   = 1'b1;
        bus.mask_data = m;
        @(negedge clk);
        bus.mask_wr   = 1'b0;
    endtask

    task automatic cfg_mode(input logic [6:0] m);
        bus.mode_wr   = 1'b1;
        bus.mode_data = m;
        @(negedge clk);
        bus.mode_wr   = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.raw_irq   = '0;
        bus.mask_wr   = 1'b0;
        bus.mask_data = '0;
        bus.mode_wr   = 1'b0;
        bus.mode_data = '0;
        bus.holdoff   = 4'd8;
        bus.ovr_clr   = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.irq_out !== 7'h00) $display("FAIL reset_irq_out: got %h expected 00", bus.irq_out);
        else n_pass++;
        n_checks++;
        if (bus.pending !== 7'h00) $display("FAIL reset_pending: got %h expected 00", bus.pending);
        else n_pass++;
        n_checks++;
        if (bus.overrun !== 7'h00) $display("FAIL reset_overrun: got %h expected 00", bus.overrun);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        cfg_mask(7'h7F);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_edge();
        int k;
        k = cyc;
        bus.holdoff = 4'd8;
        for (int t = 0; t < 8; t++) begin
            if (t == 0) begin
                bus.raw_irq[2] = 1'b1;
                push_exp(k + 3, 7'h04);
            end
            if (t == 3) begin
                n_checks++;
                if (bus.pending !== 7'h00) $display("FAIL single_pending_at_pulse: got %h expected 00", bus.pending);
                else n_pass++;
            end
            if (t == 7) begin
                n_checks++;
                if (bus.overrun !== 7'h00) $display("FAIL single_overrun: got %h expected 00", bus.overrun);
                else n_pass++;
                bus.raw_irq[2] = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL single_sb_empty: got %0d left expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_holdoff_spacing();
        int k;
        k = cyc;
        bus.holdoff = 4'd8;
        for (int t = 0; t < 16; t++) begin
            case (t)
                0: begin
                    bus.raw_irq[0] = 1'b1;
                    push_exp(k + 3, 7'h01);
                    push_exp(k + 11, 7'h01);
                end
                1: bus.raw_irq[0] = 1'b0;
                3: bus.raw_irq[0] = 1'b1;
                5: bus.raw_irq[0] = 1'b0;
                7: bus.raw_irq[0] = 1'b1;
                9: bus.raw_irq[0] = 1'b0;
                14: bus.ovr_clr = 1'b1;
                15: bus.ovr_clr = 1'b0;
                default: ;
            endcase
            if (t == 8) begin
                n_checks++;
                if (bus.pending !== 7'h01) $display("FAIL spacing_pending: got %h expected 01", bus.pending);
                else n_pass++;
                n_checks++;
                if (bus.overrun !== 7'h00) $display("FAIL spacing_no_overrun: got %h expected 00", bus.overrun);
                else n_pass++;
            end
            if (t == 12) begin
                n_checks++;
                if (bus.overrun !== 7'h01) $display("FAIL spacing_overrun_set: got %h expected 01", bus.overrun);
                else n_pass++;
            end
            if (t == 13) begin
                n_checks++;
                if (bus.pending !== 7'h00) $display("FAIL spacing_pending_cleared: got %h expected 00", bus.pending);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.overrun !== 7'h00) $display("FAIL spacing_ovr_clr: got %h expected 00", bus.overrun);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL spacing_sb_empty: got %0d left expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_level_mode();
        int k;
        cfg_mode(7'h10);
        bus.holdoff = 4'd4;
        k = cyc;
        for (int t = 0; t < 30; t++) begin
            if (t == 0) begin
                bus.raw_irq[4] = 1'b1;
                for (int n = 0; n < 6; n++) push_exp(k + 3 + 4 * n, 7'h10);
            end
            if (t == 20) bus.raw_irq[4] = 1'b0;
            if (t == 18 || t == 29) begin
                n_checks++;
                if (bus.overrun !== 7'h00) $display("FAIL level_overrun: got %h expected 00 at t=%0d", bus.overrun, t);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.pending !== 7'h00) $display("FAIL level_pending: got %h expected 00", bus.pending);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL level_sb_empty: got %0d left expected 0", sb.size());
        else n_pass++;
        cfg_mode(7'h00);
        bus.holdoff = 4'd8;
    endtask

    task automatic test_masking();
        int k;
        bus.holdoff = 4'd8;
        cfg_mask(7'h00);
        k = cyc;
        for (int t = 0; t < 28; t++) begin
            case (t)
                0:  bus.raw_irq = 7'h7F;
                5:  bus.raw_irq = 7'h00;
                6:  begin bus.mask_wr = 1'b1; bus.mask_data = 7'h04; end
                7:  bus.mask_wr = 1'b0;
                8:  begin bus.raw_irq[2] = 1'b1; push_exp(k + 11, 7'h04); end
                9:  bus.raw_irq[2] = 1'b0;
                11: bus.raw_irq[2] = 1'b1;
                12: bus.raw_irq[2] = 1'b0;
                16: bus.mask_wr = 1'b0;
                23: bus.mask_wr = 1'b0;
                default: ;
            endcase
            if (t == 3) begin
                n_checks++;
                if (bus.irq_out !== 7'h00) $display("FAIL masked_irq_out: got %h expected 00", bus.irq_out);
                else n_pass++;
            end
            if (t == 4) begin
                n_checks++;
                if (bus.pending !== 7'h00) $display("FAIL masked_pending: got %h expected 00", bus.pending);
                else n_pass++;
            end
            if (t == 15) begin
                n_checks++;
                if (bus.pending !== 7'h04) $display("FAIL mask_hold_pending: got %h expected 04", bus.pending);
                else n_pass++;
                bus.mask_wr   = 1'b1;
                bus.mask_data = 7'h00;
            end
            if (t == 22) begin
                n_checks++;
                if (bus.pending !== 7'h04) $display("FAIL mask_frozen_pending: got %h expected 04", bus.pending);
                else n_pass++;
                bus.mask_wr   = 1'b1;
                bus.mask_data = 7'h7F;
                push_exp(k + 24, 7'h04);
            end
            if (t == 26) begin
                n_checks++;
                if (bus.pending !== 7'h00) $display("FAIL unmask_pending: got %h expected 00", bus.pending);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL mask_sb_empty: got %0d left expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int k;
        bus.holdoff = 4'd0;
        k = cyc;
        for (int t = 0; t < 20; t++) begin
            bus.raw_irq[6] = (t < 16) && ((t % 4) < 2);
            if (t < 16 && (t % 4) == 0) push_exp(k + t + 3, 7'h40);
            @(negedge clk);
        end
        n_checks++;
        if (bus.overrun !== 7'h00) $display("FAIL b2b_overrun: got %h expected 00", bus.overrun);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL b2b_sb_empty: got %0d left expected 0", sb.size());
        else n_pass++;
        bus.holdoff = 4'd8;
    endtask

    task automatic test_reset_midop();
        int k;
        bus.holdoff = 4'd8;
        k = cyc;
        for (int t = 0; t < 10; t++) begin
            case (t)
                0: begin bus.raw_irq[0] = 1'b1; push_exp(k + 3, 7'h01); end
                1: bus.raw_irq[0] = 1'b0;
                3: bus.raw_irq[0] = 1'b1;
                5: bus.raw_irq[0] = 1'b0;
                7: bus.raw_irq[0] = 1'b1;
                9: bus.raw_irq[0] = 1'b0;
                default: ;
            endcase
            @(negedge clk);
        end
        n_checks++;
        if (bus.pending !== 7'h01) $display("FAIL midop_pre_pending: got %h expected 01", bus.pending);
        else n_pass++;
        n_checks++;
        if (bus.overrun !== 7'h01) $display("FAIL midop_pre_overrun: got %h expected 01", bus.overrun);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.irq_out, bus.pending, bus.overrun} !== 21'h0)
            $display("FAIL midop_async_clear: got irq=%h pend=%h ovr=%h expected all 00",
                     bus.irq_out, bus.pending, bus.overrun);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.raw_irq = 7'h7F;
        for (int t = 0; t < 6; t++) begin
            if (t == 3) begin
                n_checks++;
                if (bus.irq_out !== 7'h00) $display("FAIL post_reset_irq_out: got %h expected 00", bus.irq_out);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.pending !== 7'h00) $display("FAIL post_reset_pending: got %h expected 00", bus.pending);
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL midop_sb_empty: got %0d left expected 0", sb.size());
        else n_pass++;
        bus.raw_irq = 7'h00;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single_edge();
        test_holdoff_spacing();
        test_level_mode();
        test_masking();
        test_back_to_back();
        test_reset_midop();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/irq_conditioner.md
Name: irq_conditioner

Overview:
- Front-end conditioner that sits directly upstream of the 7-line interrupt collector.
- Takes raw, asynchronous peripheral interrupt lines and synchronises them. Applies per-line enable masks and edge/level mode.
- Emits clean single-cycle pulses on irq_out[6:0], which drive the collector's irq1..irq7 inputs (bit0 = irq1 ... bit6 = irq7).
- A per-line holdoff counter spaces repeated pulses. At the default of 8 cycles, each pulse lands in its own collector sampling slot instead of merging.

Parameters:
HOLDOFF_W, 4, width of holdoff value and per-line holdoff counters
SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
raw_irq  in  7  asynchronous peripheral interrupt lines, bit0 = line 1
mask_wr  in  1  load mask register from mask_data this edge
mask_data  in  7  1 = line enabled
mode_wr  in  1  load mode register from mode_data this edge
mode_data  in  7  1 = level mode, 0 = rising-edge mode
holdoff  in  HOLDOFF_W  minimum cycles between pulses on the same line, sampled at each emission
ovr_clr  in  1  clear all overrun flags
irq_out  out  7  registered single-cycle pulses to the collector
pending  out  7  registered; event captured, not yet emitted
overrun  out  7  registered, sticky; edge event lost because the line was already pending

Behaviour:
- Reset (rst=0, asynchronous):
  - Cleared: all synchronisers, prev-sample regs, pending, overrun, irq_out and counters.
  - mask = 7'h00 (all lines disabled); mode = 7'h00 (edge mode).
  - Outputs go 0 immediately; no pulse survives a mid-operation reset.
- Synchroniser: raw_irq[i] passes through SYNC_STAGES flops giving s[i]; p[i] holds the previous s[i].
- Event detection (combinational, per line):
  - Edge mode: ev = s & ~p.
  - Level mode: ev = s.
  - ev is gated by mask[i]. A masked line captures nothing.
- Emission condition per line: em = mask & cnt==0 & (pending | ev).
- On each edge, for each line:
  - irq_out[i] <= em. irq_out is therefore high for exactly one cycle per emission.
  - When em=1: pending <= 0 and cnt <= max(holdoff-1, 0).
  - When em=0: if cnt!=0, cnt <= cnt-1. If ev, pending <= 1.
  - holdoff of 0 or 1 allows a pulse every cycle. holdoff=8 gives a minimum 8-cycle spacing between pulse edges.
- Overrun:
  - Set when, in edge mode, ev=1 while pending=1 and em=0 (the event merged with an existing pending one).
  - Never set in level mode.
  - ovr_clr clears all bits. A simultaneous set on a line wins over the clear.
- Masking:
  - Clearing a mask bit freezes that line's pending and stops emission.
  - Re-enabling emits the held pending when cnt==0. Counters keep decrementing regardless of mask.
- Configuration:
  - Mask and mode register writes take effect for events evaluated on the edge after the write.
  - Changing mode does not clear pending.
- Latency:
  - Edge mode with SYNC_STAGES=2 and an idle line (cnt=0, pending=0, enabled): raw rising before edge E1 → s at E2 → irq_out=1 after E3 → irq_out=0 after E4.
- Lines are fully independent; any combination may pulse in the same cycle.

Test Plan:
1. Reset, then mask_wr with 7'h7F, holdoff=8. Drive raw_irq[2] 0→1 before E1 → irq_out=7'h04 for exactly one cycle, after E3; pending and overrun stay 0.
2. Line 1 in edge mode, holdoff=8. Apply two rising edges 3 cycles apart → pulses exactly 8 cycles apart, second pulse from pending; overrun=0. Add a third edge while the second is pending → overrun[0]=1. Then ovr_clr → overrun=0.
3. Line 5 in level mode, holdoff=4, raw held high 20 cycles → irq_out[4] pulses every 4 cycles, overrun[4] never set. After raw drops, at most one further pulse.
4. Mask all lines, drive raw edges on lines 1-7 → no irq_out and pending=0. Mask line 3 while it is pending → no pulse. Unmask → pulse on the edge after the write.
5. holdoff=0, line 7 edge mode, raw toggles every 2 cycles → one pulse per rising edge, no overrun.
6. Assert rst low in the cycle a pulse is due, with lines pending and counters nonzero → all outputs 0 asynchronously. After release, mask=0 and no stale pulse appears.
